// File: rtl/mesh_router.sv
// Parametrised 5-port XY wormhole mesh router: per-input flit FIFOs and FSMs,
// per-output credit counters and round-robin allocation with wormhole locking.
module mesh_router #(
    parameter int X_ID      = 0,
    parameter int Y_ID      = 0,
    parameter int MESH_X    = 4,
    parameter int MESH_Y    = 4,
    parameter int COORD_W   = 2,
    parameter int FLIT_W    = 17,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*FLIT_W-1:0] data_i,
    input  logic [4:0]          credit_i,
    output logic [5*FLIT_W-1:0] data_o,
    output logic [4:0]          credit_o,
    output logic [4:0]          err_o
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(BUF_DEPTH);
    localparam logic [COORD_W-1:0] X_C = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_ID);
    localparam logic [2:0] P_L = 3'd0;
    localparam logic [2:0] P_S = 3'd1;
    localparam logic [2:0] P_W = 3'd2;
    localparam logic [2:0] P_E = 3'd3;
    localparam logic [2:0] P_N = 3'd4;
    // Edge ports are switched off at elaboration from the router's mesh position.
    localparam logic [4:0] PORT_EN = {(Y_ID > 0), (X_ID < MESH_X - 1), (X_ID > 0),
                                      (Y_ID < MESH_Y - 1), 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FWD, S_DRAIN} in_state_e;
    typedef logic [FLIT_W-1:0] flit_t;

    flit_t            fifo_mem [5][BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [5];
    logic [PTR_W-1:0] rd_ptr_q [5];
    logic [CNT_W-1:0] count_q  [5];
    logic [CNT_W-1:0] count_d  [5];
    in_state_e        state_q  [5];
    logic [2:0]       route_q  [5];
    logic [4:0]       busy_q;
    logic [2:0]       rr_q     [5];
    logic [CNT_W-1:0] credit_q [5];
    logic [CNT_W-1:0] credit_d [5];
    flit_t            data_o_q [5];

    flit_t      din      [5];
    flit_t      front    [5];
    logic [2:0] route_c  [5];
    logic [2:0] tgt      [5];
    logic [4:0] gnt      [5];
    logic [2:0] gnt_idx  [5];
    flit_t      out_flit [5];
    logic [4:0] req, fwd, pop, do_push, err_set, granted, out_v, out_tail;

    for (genvar gi = 0; gi < 5; gi++) begin : g_port
        assign din[gi] = data_i[gi*FLIT_W +: FLIT_W];
        assign data_o[gi*FLIT_W +: FLIT_W] = data_o_q[gi];
    end

    // XY route of the flit at each FIFO front; the stored route is used once past IDLE.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            front[i] = fifo_mem[i][rd_ptr_q[i]];
            if (front[i][2*COORD_W-1:COORD_W] > X_C)      route_c[i] = P_E;
            else if (front[i][2*COORD_W-1:COORD_W] < X_C) route_c[i] = P_W;
            else if (front[i][COORD_W-1:0] > Y_C)         route_c[i] = P_S;
            else if (front[i][COORD_W-1:0] < Y_C)         route_c[i] = P_N;
            else                                          route_c[i] = P_L;
            tgt[i] = (state_q[i] == S_IDLE) ? route_c[i] : route_q[i];
            req[i] = ((state_q[i] == S_IDLE) && (count_q[i] != '0) && front[i][FLIT_W-2]
                      && PORT_EN[route_c[i]]) || (state_q[i] == S_REQ);
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        granted = '0;
        for (int o = 0; o < 5; o++) begin
            gnt[o]     = '0;
            gnt_idx[o] = '0;
            if (PORT_EN[o] && !busy_q[o] && (credit_q[o] != '0)) begin
                for (int k = 1; k <= 5; k++) begin
                    idx = (int'(rr_q[o]) + k) % 5;
                    if ((gnt[o] == '0) && req[idx] && (tgt[idx] == 3'(o))) begin
                        gnt[o][idx] = 1'b1;
                        gnt_idx[o]  = 3'(idx);
                    end
                end
            end
            granted = granted | gnt[o];
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            fwd[i]     = 1'b0;
            pop[i]     = 1'b0;
            err_set[i] = 1'b0;
            case (state_q[i])
                S_IDLE: if (count_q[i] != '0) begin
                    if (!front[i][FLIT_W-2]) begin
                        pop[i]     = 1'b1;
                        err_set[i] = 1'b1;
                    end else if (!PORT_EN[route_c[i]]) begin
                        err_set[i] = 1'b1;
                    end else begin
                        fwd[i] = granted[i];
                    end
                end
                S_REQ:   fwd[i] = granted[i];
                S_FWD:   fwd[i] = (count_q[i] != '0) && (credit_q[route_q[i]] != '0);
                S_DRAIN: pop[i] = (count_q[i] != '0);
                default: fwd[i] = 1'b0;
            endcase
            pop[i] = pop[i] | fwd[i];
            // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
            do_push[i] = PORT_EN[i] && din[i][FLIT_W-1] && ((count_q[i] != CNT_MAX) || pop[i]);
            if (PORT_EN[i] && din[i][FLIT_W-1] && (count_q[i] == CNT_MAX) && !pop[i]) begin
                err_set[i] = 1'b1;
            end
            err_set[i] = err_set[i] & PORT_EN[i];
            count_d[i] = count_q[i] + CNT_W'(do_push[i]) - CNT_W'(pop[i]);
        end
    end

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            out_v[o]    = 1'b0;
            out_flit[o] = '0;
            for (int i = 0; i < 5; i++) begin
                if (fwd[i] && (tgt[i] == 3'(o))) begin
                    out_v[o]    = 1'b1;
                    out_flit[o] = front[i];
                end
            end
            out_tail[o] = out_flit[o][FLIT_W-3];
            credit_d[o] = credit_q[o];
            if (out_v[o] && !(credit_i[o] && PORT_EN[o])) begin
                credit_d[o] = credit_q[o] - CNT_W'(1);
            end else if (!out_v[o] && credit_i[o] && PORT_EN[o] && (credit_q[o] != CNT_MAX)) begin
                credit_d[o] = credit_q[o] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (do_push[i]) fifo_mem[i][wr_ptr_q[i]] <= din[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                state_q[i]  <= S_IDLE;
                route_q[i]  <= P_L;
                rr_q[i]     <= '0;
                credit_q[i] <= CNT_MAX;
                data_o_q[i] <= '0;
            end
            busy_q   <= '0;
            credit_o <= '0;
            err_o    <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(do_push[i]);
                rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(pop[i]);
                count_q[i]  <= count_d[i];
                case (state_q[i])
                    S_IDLE: if ((count_q[i] != '0) && front[i][FLIT_W-2]) begin
                        route_q[i] <= route_c[i];
                        if (!PORT_EN[route_c[i]])     state_q[i] <= S_DRAIN;
                        else if (!granted[i])         state_q[i] <= S_REQ;
                        else if (!front[i][FLIT_W-3]) state_q[i] <= S_FWD;
                    end
                    S_REQ:   if (granted[i]) state_q[i] <= front[i][FLIT_W-3] ? S_IDLE : S_FWD;
                    S_FWD:   if (fwd[i] && front[i][FLIT_W-3]) state_q[i] <= S_IDLE;
                    S_DRAIN: if (pop[i] && front[i][FLIT_W-3]) state_q[i] <= S_IDLE;
                    default: state_q[i] <= S_IDLE;
                endcase
            end
            for (int o = 0; o < 5; o++) begin
                credit_q[o] <= credit_d[o];
                data_o_q[o] <= out_flit[o];
                // A single-flit packet never locks the output.
                if (!busy_q[o]) begin
                    if (gnt[o] != '0) begin
                        rr_q[o]   <= gnt_idx[o];
                        busy_q[o] <= !out_tail[o];
                    end
                end else if (out_v[o] && out_tail[o]) begin
                    busy_q[o] <= 1'b0;
                end
            end
            credit_o <= pop & PORT_EN;
            err_o    <= err_o | err_set;
        end
    end
endmodule

// File: tb/tb_mesh_router.sv
// Directed bench for mesh_router: router A at (1,1) in a 4x4 mesh, router B at (0,0)
// in a one-column mesh so that an east-bound head is unroutable.
module tb_mesh_router;
    localparam int FW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5*FW-1:0] a_data_i = '0, a_data_o, b_data_i = '0, b_data_o;
    logic [4:0]    a_credit_i = '0, a_credit_o, a_err_o;
    logic [4:0]    b_credit_i = '0, b_credit_o, b_err_o;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    mesh_router #(.X_ID(1), .Y_ID(1), .MESH_X(4), .MESH_Y(4), .COORD_W(2), .FLIT_W(FW), .BUF_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .data_i(a_data_i), .credit_i(a_credit_i),
        .data_o(a_data_o), .credit_o(a_credit_o), .err_o(a_err_o));

    mesh_router #(.X_ID(0), .Y_ID(0), .MESH_X(1), .MESH_Y(4), .COORD_W(2), .FLIT_W(FW), .BUF_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .data_i(b_data_i), .credit_i(b_credit_i),
        .data_o(b_data_o), .credit_o(b_credit_o), .err_o(b_err_o));

    typedef struct {
        logic [1:0] dx;
        logic [1:0] dy;
        int         port;
    } vec_t;

    function automatic logic [FW-1:0] mk_head(input logic [1:0] x, input logic [1:0] y,
                                              input logic t, input logic [9:0] tag);
        return {1'b1, 1'b1, t, tag, x, y};
    endfunction

    function automatic logic [FW-1:0] mk_body(input logic t, input logic [13:0] tag);
        return {1'b1, 1'b0, t, tag};
    endfunction

    function automatic logic [FW-1:0] sl(input logic [5*FW-1:0] v, input int p);
        return v[p*FW +: FW];
    endfunction

    function automatic logic [FW-1:0] rr_flit(input int src, input int k);
        if (k == 0) return mk_head(2'd1, 2'd1, 1'b0, 10'(src));
        return mk_body(k == 2, 14'(src * 16 + k));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        a_data_i = '0; b_data_i = '0; a_credit_i = '0; b_credit_i = '0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic rr_round(input int pa, input int pb, input int first);
        logic [FW-1:0] got[$];
        logic [FW-1:0] exp_q[$];
        logic [FW-1:0] f;
        int second;
        second = (first == pa) ? pb : pa;
        for (int k = 0; k < 3; k++) exp_q.push_back(rr_flit(first, k));
        for (int k = 0; k < 3; k++) exp_q.push_back(rr_flit(second, k));
        for (int c = 0; c < 14; c++) begin
            a_data_i = '0;
            if (c < 3) begin
                a_data_i[pa*FW +: FW] = rr_flit(pa, c);
                a_data_i[pb*FW +: FW] = rr_flit(pb, c);
            end
            tick();
            a_credit_i = '0;
            f = sl(a_data_o, 0);
            if (f[FW-1]) begin
                got.push_back(f);
                a_credit_i[0] = 1'b1;
            end
        end
        a_credit_i = '0;
        $display("rr round: inputs %0d,%0d -> expect %0d first, %0d flits seen", pa, pb, first, got.size());
        chk("rr_len", 128'(got.size()), 128'(6));
        for (int i = 0; i < 6; i++) begin
            f = (i < got.size()) ? got[i] : '0;
            chk("rr_order", 128'(f), 128'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[8];
        logic [FW-1:0] fl, f, lf[5], wf[5];
        logic [5*FW-1:0] expv;
        logic [FW-1:0] got[$];
        int            ccnt, dcnt;

        vecs[0] = '{2'd3, 2'd1, 3};
        vecs[1] = '{2'd0, 2'd1, 2};
        vecs[2] = '{2'd1, 2'd3, 1};
        vecs[3] = '{2'd1, 2'd0, 4};
        vecs[4] = '{2'd1, 2'd1, 0};
        vecs[5] = '{2'd2, 2'd0, 3};
        vecs[6] = '{2'd0, 2'd3, 2};
        vecs[7] = '{2'd1, 2'd2, 1};

        #1 rst = 1'b0;
        tick();
        tick();
        chk("rst_a_data", 128'(a_data_o), 128'(0));
        chk("rst_a_credit", 128'(a_credit_o), 128'(0));
        chk("rst_a_err", 128'(a_err_o), 128'(0));
        chk("rst_b_data", 128'(b_data_o), 128'(0));
        chk("rst_b_credit", 128'(b_credit_o), 128'(0));
        chk("rst_b_err", 128'(b_err_o), 128'(0));
        rst = 1'b1;
        tick();

        // XY routing table from the Local input of A
        for (int v = 0; v < 8; v++) begin
            fl = mk_head(vecs[v].dx, vecs[v].dy, 1'b1, 10'(v));
            a_data_i[0 +: FW] = fl;
            tick();
            a_data_i = '0;
            tick();
            expv = (5*FW)'(fl) << (vecs[v].port * FW);
            $display("route vec %0d: dest (%0d,%0d) -> port %0d", v, vecs[v].dx, vecs[v].dy, vecs[v].port);
            chk("route_data", 128'(a_data_o), 128'(expv));
            chk("route_credit", 128'(a_credit_o), 128'(5'b00001));
            tick();
            chk("route_idle_data", 128'(a_data_o), 128'(0));
            chk("route_idle_credit", 128'(a_credit_o), 128'(0));
            a_credit_i[vecs[v].port] = 1'b1;
            tick();
            a_credit_i = '0;
        end

        // B: North disabled input ignored, Local to South
        b_data_i[0 +: FW]  = mk_head(2'd0, 2'd2, 1'b1, 10'd5);
        b_data_i[4*FW +: FW] = mk_head(2'd0, 2'd2, 1'b1, 10'd6);
        b_credit_i[4] = 1'b1;
        tick();
        b_data_i = '0;
        b_credit_i = '0;
        tick();
        $display("B: local packet to South, North input ignored");
        chk("b_south", 128'(b_data_o), 128'((5*FW)'(mk_head(2'd0, 2'd2, 1'b1, 10'd5)) << FW));
        chk("b_credit", 128'(b_credit_o), 128'(5'b00001));
        b_credit_i[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            b_credit_i = '0;
            chk("b_north_quiet", 128'(sl(b_data_o, 4)), 128'(0));
        end
        chk("b_err_clean", 128'(b_err_o), 128'(0));

        // B: east-bound head is unroutable and drained
        lf[0] = mk_head(2'd1, 2'd0, 1'b0, 10'd7);
        lf[1] = mk_body(1'b0, 14'h71);
        lf[2] = mk_body(1'b1, 14'h72);
        ccnt = 0; dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            b_data_i = '0;
            if (c < 3) b_data_i[0 +: FW] = lf[c];
            tick();
            if (b_credit_o[0]) ccnt++;
            if (b_data_o != '0) dcnt++;
        end
        b_data_i = '0;
        $display("B drain: %0d credit pulses, %0d data cycles", ccnt, dcnt);
        chk("drain_credits", 128'(ccnt), 128'(3));
        chk("drain_no_data", 128'(dcnt), 128'(0));
        chk("drain_err", 128'(b_err_o), 128'(5'b00001));

        // Round-robin on the Local output
        do_reset();
        rr_round(3, 2, 2);
        rr_round(3, 2, 2);
        rr_round(4, 2, 4);

        // Credit stall on East plus overflow on a blocked West input
        do_reset();
        lf[0] = mk_head(2'd3, 2'd1, 1'b0, 10'h21);
        wf[0] = mk_head(2'd3, 2'd1, 1'b0, 10'h31);
        for (int k = 1; k < 5; k++) begin
            lf[k] = mk_body(k == 4, 14'(32 + k));
            wf[k] = mk_body(k == 4, 14'(48 + k));
        end
        ccnt = 0;
        got.delete();
        for (int c = 0; c < 10; c++) begin
            a_data_i = '0;
            if (c < 5) a_data_i[0 +: FW] = lf[c];
            tick();
            f = sl(a_data_o, 3);
            if (f[FW-1]) got.push_back(f);
            if (a_credit_o[0]) ccnt++;
        end
        a_data_i = '0;
        $display("stall: %0d flits forwarded with no credit return", got.size());
        chk("stall_count", 128'(got.size()), 128'(4));
        chk("stall_credit_o", 128'(ccnt), 128'(4));
        for (int i = 0; i < 4; i++) begin
            f = (i < got.size()) ? got[i] : '0;
            chk("stall_order", 128'(f), 128'(lf[i]));
        end
        for (int c = 0; c < 5; c++) begin
            a_data_i = '0;
            a_data_i[2*FW +: FW] = wf[c];
            tick();
            if (c == 3) chk("ovf_before", 128'(a_err_o), 128'(0));
            if (c == 4) chk("ovf_err", 128'(a_err_o), 128'(5'b00100));
        end
        a_data_i = '0;
        a_credit_i[3] = 1'b1;
        tick();
        a_credit_i = '0;
        chk("stall_hold", 128'(sl(a_data_o, 3)), 128'(0));
        tick();
        $display("stall: one credit returned, tail released");
        chk("stall_tail", 128'(sl(a_data_o, 3)), 128'(lf[4]));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("east_no_credit", 128'(sl(a_data_o, 3)), 128'(0));
        end
        chk("ovf_sticky", 128'(a_err_o), 128'(5'b00100));
        do_reset();
        chk("ovf_cleared", 128'(a_err_o), 128'(0));

        // Reset in the middle of a packet
        a_data_i[0 +: FW] = mk_head(2'd3, 2'd1, 1'b0, 10'h41);
        tick();
        a_data_i[0 +: FW] = mk_body(1'b0, 14'h42);
        tick();
        a_data_i = '0;
        chk("mid_head", 128'(sl(a_data_o, 3)), 128'(mk_head(2'd3, 2'd1, 1'b0, 10'h41)));
        rst = 1'b0;
        #1;
        $display("reset asserted mid-packet");
        chk("mid_rst_data", 128'(a_data_o), 128'(0));
        chk("mid_rst_credit", 128'(a_credit_o), 128'(0));
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_data", 128'(a_data_o), 128'(0));
            chk("post_rst_credit", 128'(a_credit_o), 128'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
